// File: rtl/seg7_scan_if.sv
// Signal bundle between a display controller and the multiplexed 7-segment scan driver.
// The master side supplies value/settings; the slave side drives the display lines.
interface seg7_scan_if #(
  parameter int DIGITS     = 4,
  parameter int BITS       = 16,
  parameter int PRESCALE_W = 16
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BITS-1:0]       value;
  logic                  load;
  logic                  enable;
  logic [PRESCALE_W-1:0] prescale;
  logic [3:0]            blank_cycles;
  logic                  lzb_en;
  logic [6:0]            segments_out;
  logic [DIGITS-1:0]     digit_sel;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_done;

  modport master (
    output value, load, enable, prescale, blank_cycles, lzb_en,
    input  segments_out, digit_sel, digit_idx, frame_done
  );

  modport slave (
    input  value, load, enable, prescale, blank_cycles, lzb_en,
    output segments_out, digit_sel, digit_idx, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display scanner: snapshots a value once per frame and walks it
// across DIGITS one-hot digit selects, with optional blanking gaps and leading-zero blanking.
//
//   state | meaning
//   IDLE  | scanning disabled, all lines off
//   BLANK | anti-ghost gap before a digit, all lines off
//   SHOW  | current digit driven for prescale+1 cycles
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int BITS       = 16,
  parameter int PRESCALE_W = 16
) (
  input logic       clk,
  input logic       reset_n,
  seg7_scan_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                state_q, state_d;
  logic [BITS-1:0]       snap_q, snap_d;
  logic [BITS-1:0]       staging_q, staging_d;
  logic                  pending_q, pending_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic                  fd_q, fd_d;
  logic                  frame_start, enter_digit;
  logic [DIGITS-1:0]     tail_zero;
  logic [3:0]            nib;
  logic                  lz_blank, all_zero, show_on;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    frame_start = 1'b0;
    enter_digit = 1'b0;
    fd_d        = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          frame_start = 1'b1;
          idx_d       = '0;
          enter_digit = 1'b1;
        end
        BLANK: begin
          if (cnt_q == '0) begin
            state_d = SHOW;
            cnt_d   = bus.prescale;
          end else begin
            cnt_d = cnt_q - PRESCALE_W'(1);
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            enter_digit = 1'b1;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
              idx_d       = '0;
              frame_start = 1'b1;
              fd_d        = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q - PRESCALE_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      // Dwell and gap lengths are latched here so mid-phase setting changes wait for the next phase.
      if (enter_digit) begin
        if (bus.blank_cycles == 4'd0) begin
          state_d = SHOW;
          cnt_d   = bus.prescale;
        end else begin
          state_d = BLANK;
          cnt_d   = PRESCALE_W'(bus.blank_cycles - 4'd1);
        end
      end
    end
  end

  // Transfer reads the pre-edge staging, so a load coinciding with frame start waits a frame.
  always_comb begin
    snap_d    = (frame_start && pending_q) ? staging_q : snap_q;
    staging_d = bus.load ? bus.value : staging_q;
    pending_d = bus.load ? 1'b1 : (frame_start ? 1'b0 : pending_q);
  end

  // Outputs are derived from next-state values so segments and select switch on the same edge.
  always_comb begin
    tail_zero = '0;
    all_zero  = 1'b1;
    nib       = 4'h0;
    lz_blank  = 1'b0;
    seg_d     = 7'h00;
    sel_d     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (snap_d[4*i +: 4] == 4'h0);
      tail_zero[i] = all_zero;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib      = snap_d[4*i +: 4];
        lz_blank = bus.lzb_en && (i != 0) && tail_zero[i];
      end
    end
    show_on = (state_d == SHOW) && !lz_blank;
    if (show_on) seg_d = hex_to_seg(nib);
    for (int i = 0; i < DIGITS; i++) begin
      sel_d[i] = show_on && (idx_d == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      staging_q <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      seg_q     <= 7'h00;
      sel_q     <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      staging_q <= staging_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.segments_out = seg_q;
  assign bus.digit_sel    = sel_q;
  assign bus.digit_idx    = idx_q;
  assign bus.frame_done   = fd_q;
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed multi-digit 7-segment display driver, downstream of the counter.
- Consumes the full counter value, not just the lowest nibble, and scans it across DIGITS hex digits on shared segment lines.
- Each digit has a one-hot select line.
- Supports tear-free snapshot update, programmable dwell time, inter-digit anti-ghost blanking and leading-zero blanking.

Parameters:
- DIGITS, 4, number of hex digits scanned.
- BITS, 16, width of input value; must equal 4*DIGITS.
- PRESCALE_W, 16, width of the dwell-time setting.

Ports:
- clk  input  1  scan clock.
- reset_n  input  1  asynchronous, active-low reset.
- value  input  BITS  value to display; nibble i drives digit i.
- load  input  1  request capture of value.
- enable  input  1  scanning enable.
- prescale  input  PRESCALE_W  dwell per digit, in cycles minus one.
- blank_cycles  input  4  inter-digit all-off cycles; 0 means no blank phase.
- lzb_en  input  1  leading-zero blanking enable.
- segments_out  output  7  active-high segments; bit 6 = g … bit 0 = a, same coding as the existing hex decoder.
- digit_sel  output  DIGITS  one-hot active-high digit select.
- digit_idx  output  clog2(DIGITS)  index of the digit currently being scanned.
- frame_done  output  1  one-cycle pulse at end of each full scan.

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE.
  - snap, staging, pending, dwell counter, digit_idx all 0.
  - segments_out=0, digit_sel=0, frame_done=0.
- Capture:
  - load=1 on a clock edge: staging<=value, pending<=1.
  - Repeated loads before transfer overwrite staging; last one wins.
- Transfer:
  - snap<=staging, pending<=0 only at frame start, i.e. entry to digit 0 from IDLE or from wrap.
  - A frame never mixes two snapshots.
  - load on the same edge as a frame start: the transfer uses the old staging; new data is held pending for the next frame.
- States: IDLE, BLANK, SHOW.
  - IDLE:
    - Outputs 0.
    - If enable=1, go to BLANK for digit 0, or straight to SHOW if blank_cycles==0. Frame start applies.
  - BLANK:
    - segments_out=0, digit_sel=0.
    - Lasts blank_cycles cycles; blank_cycles is sampled on entry.
    - Then go to SHOW for the same digit.
  - SHOW:
    - digit_sel=1<<digit_idx; segments_out=decode(snap nibble digit_idx).
    - Lasts prescale+1 cycles; prescale is sampled on entry, so prescale=0 gives 1 cycle.
    - On the last cycle, digit_idx increments, wrapping DIGITS-1 to 0. Next state is BLANK, or SHOW if blank_cycles==0.
    - Wrap to 0 is a frame start.
- frame_done:
  - Registered; high for exactly the cycle after the last SHOW cycle of digit DIGITS-1.
- Leading-zero blanking:
  - When lzb_en=1 and i>0 and snap nibbles i..DIGITS-1 are all zero, digit i shows segments_out=0 and digit_sel=0.
  - Timing is unchanged: the slot is still consumed.
  - Digit 0 is never blanked.
- enable falling:
  - Next edge enters IDLE from any state; digit_idx<=0; no frame_done.
  - pending and staging are retained.
- Settings:
  - prescale and blank_cycles changes mid-phase take effect on the next phase entry.
- Outputs are registered: segments_out and digit_sel change together on the state-transition edge, with no glitch between them.
- digit_sel is never more than one-hot.

Test Plan:
- Reset, load value=16'h1234, enable=1, prescale=0, blank_cycles=0, lzb_en=0 -> per cycle digit_sel 0001,0010,0100,1000 repeating. segments_out 7'b1100110 (4), 7'b1001111 (3), 7'b1011011 (2), 7'b0000110 (1). frame_done every 4th cycle.
- prescale=2, blank_cycles=1 -> each digit: 1 cycle all-off then 3 cycles shown. Frame period 16 cycles.
- value=16'h0070, lzb_en=1 -> digits 3,2 off (digit_sel=0). Digit 1 shows 7'b0000111, digit 0 shows 7'b0111111.
- Mid-frame load value=16'hABCD while showing 16'h1234 -> remainder of frame still shows 1234. Next frame shows D,C,B,A.
- Deassert enable mid-SHOW of digit 2 -> next cycle outputs 0, digit_idx=0. Re-enable restarts at digit 0.
- Assert reset_n low asynchronously mid-BLANK -> outputs 0 immediately without a clock edge. After release with enable=1, first frame shows 0000.
